riscv_mem_port_arbiter: RTL and testbench
=========================================

// Module: riscv_mem_port_arbiter
// PURPOSE
//  Shares one backing-memory port between the instruction-cache miss path (read-only) and the
//  data-cache path (LW miss refill, SW write-through) of the 5-stage RISC-V pipeline.
//  Serialises the two requesters, sequences each memory transaction, and drives the pipeline
//  stall lines (IF, MEM) while a requester is waiting. Sits between the caches and main memory.
// PARAMETERS
//  ADDR_W        32   address width, byte addressed
//  DATA_W        32   data word width
//  MAX_D_STREAK  4    consecutive D grants allowed while i_req pending before I is forced (>=1)
//  TIMEOUT       255  cycles in ISSUE without mem_ready before the transaction is aborted (>=1)
// PORTS
//  clock      in   1       rising-edge clock
//  reset      in   1       asynchronous, active-high reset
//  i_req      in   1       I-cache read request; held with i_addr stable until i_ack
//  i_addr     in   ADDR_W  I-cache read address
//  i_ack      out  1       one-cycle pulse: I transaction complete, i_rdata valid
//  i_rdata    out  DATA_W  I read data, registered, held until next I completion
//  d_req      in   1       D-cache request; held with d_we/d_addr/d_wdata stable until d_ack
//  d_we       in   1       1 = write (SW), 0 = read (LW refill)
//  d_addr     in   ADDR_W  D address
//  d_wdata    in   DATA_W  D write data
//  d_ack      out  1       one-cycle pulse: D transaction complete
//  d_rdata    out  DATA_W  D read data, registered; unchanged by writes
//  mem_req    out  1       memory request, held until mem_ready sampled high
//  mem_we     out  1       memory write enable, valid with mem_req
//  mem_addr   out  ADDR_W  word-aligned memory address ([1:0] forced to 0)
//  mem_wdata  out  DATA_W  memory write data
//  mem_ready  in   1       memory completes the current request this cycle
//  mem_rdata  in   DATA_W  memory read data, valid when mem_ready=1
//  stall_if   out  1       = i_req & ~i_ack (combinational)
//  stall_mem  out  1       = d_req & ~d_ack (combinational)
//  busy       out  1       state != IDLE
//  err_timeout out 1       sticky: a transaction was aborted by timeout; cleared only by reset
// BEHAVIOUR
//  - Reset: state=IDLE; all registered outputs 0 (acks, rdatas, mem_*, err_timeout); streak=0,
//    tcnt=0. Async: mem_req drops immediately even mid-transaction; no ack for the abandoned op.
//  - FSM: IDLE -> ISSUE -> RESP -> IDLE.
//  - IDLE: if any req, choose owner, latch addr/we/wdata into mem_* regs, go ISSUE
//    (mem_req=1 from the next cycle). No req: stay.
//  - Arbitration: D wins over I, except I wins when i_req & streak==MAX_D_STREAK. Only one
//    requesting -> that one. Streak increments (saturating) on a D grant while i_req=1, holds
//    on a D grant with i_req=0, clears on any I grant.
//  - ISSUE: hold mem_* stable. mem_ready=1 -> capture mem_rdata into owner's rdata (reads only),
//    mem_req=0, go RESP. Else tcnt++; tcnt==TIMEOUT -> mem_req=0, rdata=0 (reads),
//    err_timeout=1, go RESP. tcnt clears on entering ISSUE.
//  - RESP: owner's ack=1 for exactly this cycle; no arbitration; go IDLE.
//  - Requesters drop req at the edge on which they sample ack; a req still high in the
//    following IDLE is a new request.
//  - Latency, zero-wait memory: req seen in IDLE cycle n -> mem_req cycle n+1 -> ack cycle n+2;
//    each mem_ready wait cycle adds 1. Back-to-back minimum spacing: 3 cycles per transaction.
//  - Only one transaction outstanding; the non-owner's req is held and its stall stays high.
// STRUCTURE
//  - Shared package riscv_mem_pkg: state encoding (ST_IDLE, ST_ISSUE, ST_RESP),
//    owner encoding (OWN_I, OWN_D).
//  - Sub-module riscv_mem_arb_select: combinational grant from i_req, d_req, streak.
//    FSM, latches, timeout counter in top.
// TESTING
//  1 I-only, mem_ready=1: i_req c0 i_addr=0x8 -> mem_req c1 mem_addr=0x8 mem_we=0;
//    i_ack c2 i_rdata=mem_rdata (0x00A00093); stall_if=1 c0-c1, 0 c2.
//  2 i_req & d_req(read, 0x4) both c0 -> D owns c1, d_ack c2; I issued c4, i_ack c5;
//    stall_if high c0-c4.
//  3 MAX_D_STREAK=4, d_req and i_req held high continuously -> grant order D,D,D,D,I,D...;
//    streak=0 after I grant.
//  4 D write d_addr=0x13 d_wdata=0xDEADBEEF, mem_ready low c1-c3 high c4 ->
//    mem_addr=0x10, mem_we=1 c1-c4; d_ack c5; d_rdata unchanged.
//  5 TIMEOUT=8, mem_ready stuck 0, I read c0 -> mem_req c1-c8, i_ack c9 i_rdata=0,
//    err_timeout=1 from c9 until reset.
//  6 Reset pulse during ISSUE (c2) -> mem_req, busy 0 same cycle; no ack;
//    i_req still high after release -> serviced from IDLE, err_timeout=0.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// rtl/riscv_mem_pkg.sv - shared FSM and owner encodings for the memory port arbiter
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

endpackage

// File: rtl/riscv_mem_arb_select.sv
// rtl/riscv_mem_arb_select.sv - combinational choice of the next memory port owner
module riscv_mem_arb_select
    import riscv_mem_pkg::*;
#(
    parameter int MAX_D_STREAK = 4,
    parameter int STREAK_W     = 3
) (
    input  logic                i_req_i,
    input  logic                d_req_i,
    input  logic [STREAK_W-1:0] streak_i,
    output logic                grant_valid_o,
    output owner_e              grant_owner_o
);

    logic streak_full;

    always_comb begin
        streak_full   = (streak_i == STREAK_W'(MAX_D_STREAK));
        grant_valid_o = i_req_i | d_req_i;
        grant_owner_o = OWN_D;
        // D normally wins; a full D streak hands the port to a waiting fetch
        if (i_req_i && (!d_req_i || streak_full)) begin
            grant_owner_o = OWN_I;
        end
    end

endmodule

// File: rtl/riscv_mem_port_arbiter.sv
// rtl/riscv_mem_port_arbiter.sv - shares one memory port between the I-cache and D-cache paths
module riscv_mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              busy,
    output logic              err_timeout
);

    localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
    localparam int TCNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);
    localparam logic [TCNT_W-1:0]   TCNT_LAST  = TCNT_W'(TIMEOUT - 1);

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                i_ack_q, i_ack_d;
    logic                d_ack_q, d_ack_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                err_q, err_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;

    logic   grant_valid;
    owner_e grant_owner;

    // memory is word addressed; the byte offset bits are intentionally dropped
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{i_addr[1:0], d_addr[1:0]};

    riscv_mem_arb_select #(
        .MAX_D_STREAK (MAX_D_STREAK),
        .STREAK_W     (STREAK_W)
    ) u_arb_select (
        .i_req_i       (i_req),
        .d_req_i       (d_req),
        .streak_i      (streak_q),
        .grant_valid_o (grant_valid),
        .grant_owner_o (grant_owner)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_ack_d     = 1'b0;
        d_ack_d     = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        err_d       = err_q;
        streak_d    = streak_q;
        tcnt_d      = tcnt_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    state_d   = ST_ISSUE;
                    owner_d   = grant_owner;
                    mem_req_d = 1'b1;
                    tcnt_d    = '0;
                    if (grant_owner == OWN_I) begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = {i_addr[ADDR_W-1:2], 2'b00};
                        mem_wdata_d = '0;
                        streak_d    = '0;
                    end else begin
                        mem_we_d    = d_we;
                        mem_addr_d  = {d_addr[ADDR_W-1:2], 2'b00};
                        mem_wdata_d = d_wdata;
                        // streak only measures how long a pending fetch has been starved
                        if (i_req && streak_q != STREAK_MAX) begin
                            streak_d = streak_q + 1'b1;
                        end
                    end
                end
            end
            ST_ISSUE: begin
                if (mem_ready || tcnt_q == TCNT_LAST) begin
                    state_d   = ST_RESP;
                    mem_req_d = 1'b0;
                    if (!mem_ready) begin
                        err_d = 1'b1;
                    end
                    if (owner_q == OWN_I) begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = mem_ready ? mem_rdata : '0;
                    end else begin
                        d_ack_d = 1'b1;
                        if (!mem_we_q) begin
                            d_rdata_d = mem_ready ? mem_rdata : '0;
                        end
                    end
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_I;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            err_q       <= 1'b0;
            streak_q    <= '0;
            tcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_ack_q     <= i_ack_d;
            d_ack_q     <= d_ack_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            err_q       <= err_d;
            streak_q    <= streak_d;
            tcnt_q      <= tcnt_d;
        end
    end

    assign i_ack       = i_ack_q;
    assign d_ack       = d_ack_q;
    assign i_rdata     = i_rdata_q;
    assign d_rdata     = d_rdata_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign err_timeout = err_q;
    assign busy        = (state_q != ST_IDLE);
    assign stall_if    = i_req & ~i_ack_q;
    assign stall_mem   = d_req & ~d_ack_q;

endmodule

// File: tb/tb_riscv_mem_port_arbiter.sv
// tb/tb_riscv_mem_port_arbiter.sv - directed and randomized checks for the memory port arbiter
module tb_riscv_mem_port_arbiter;

    localparam int MAXS = 4;
    localparam int TMO  = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        stall_if;
    logic        stall_mem;
    logic        busy;
    logic        err_timeout;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    riscv_mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(MAXS), .TIMEOUT(TMO)
    ) dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem), .busy(busy), .err_timeout(err_timeout)
    );

    task automatic clear_inputs();
        i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        mem_ready = 0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic next_cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        i_req = 1; d_req = 1;
        @(posedge clock);
        @(negedge clock);
        checks++; if ({mem_req, busy, i_ack, d_ack, err_timeout, mem_we} !== 6'b0) begin errors++; $display("FAIL reset_ctrl got %b exp 000000", {mem_req, busy, i_ack, d_ack, err_timeout, mem_we}); end
        checks++; if (i_rdata !== 32'h0 || d_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h/%h exp 0/0", i_rdata, d_rdata); end
        checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem got %h/%h exp 0/0", mem_addr, mem_wdata); end
        checks++; if (stall_if !== 1'b1 || stall_mem !== 1'b1) begin errors++; $display("FAIL reset_stall got %b%b exp 11", stall_if, stall_mem); end
    endtask

    task automatic test_i_read();
        do_reset();
        i_req = 1; i_addr = 32'h8; mem_ready = 1; mem_rdata = 32'h00A00093;
        @(negedge clock);
        checks++; if (stall_if !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL t1_c0 stall_if=%b mem_req=%b exp 1/0", stall_if, mem_req); end
        next_cyc(); @(negedge clock);
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h8 || mem_we !== 1'b0) begin errors++; $display("FAIL t1_c1_mem req=%b addr=%h we=%b exp 1/8/0", mem_req, mem_addr, mem_we); end
        checks++; if (stall_if !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL t1_c1_stall stall_if=%b busy=%b exp 1/1", stall_if, busy); end
        next_cyc(); @(negedge clock);
        checks++; if (i_ack !== 1'b1 || i_rdata !== 32'h00A00093) begin errors++; $display("FAIL t1_c2_ack ack=%b rdata=%h exp 1/00a00093", i_ack, i_rdata); end
        checks++; if (stall_if !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL t1_c2_stall stall_if=%b mem_req=%b exp 0/0", stall_if, mem_req); end
        next_cyc(); i_req = 0; @(negedge clock);
        checks++; if (i_ack !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL t1_c3 ack=%b busy=%b exp 0/0", i_ack, busy); end
    endtask

    task automatic test_d_priority();
        do_reset();
        i_req = 1; i_addr = 32'h20; d_req = 1; d_we = 0; d_addr = 32'h4;
        mem_ready = 1; mem_rdata = 32'h11111111;
        @(negedge clock);
        checks++; if (stall_if !== 1'b1 || stall_mem !== 1'b1) begin errors++; $display("FAIL t2_c0 stall got %b%b exp 11", stall_if, stall_mem); end
        next_cyc(); @(negedge clock);
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h4 || mem_we !== 1'b0) begin errors++; $display("FAIL t2_c1_dissue req=%b addr=%h we=%b exp 1/4/0", mem_req, mem_addr, mem_we); end
        next_cyc(); @(negedge clock);
        checks++; if (d_ack !== 1'b1 || i_ack !== 1'b0 || d_rdata !== 32'h11111111) begin errors++; $display("FAIL t2_c2_dack d_ack=%b i_ack=%b d_rdata=%h exp 1/0/11111111", d_ack, i_ack, d_rdata); end
        checks++; if (stall_if !== 1'b1 || stall_mem !== 1'b0) begin errors++; $display("FAIL t2_c2_stall got %b%b exp 10", stall_if, stall_mem); end
        next_cyc(); d_req = 0; mem_rdata = 32'h22222222; @(negedge clock);
        checks++; if (mem_req !== 1'b0 || stall_if !== 1'b1) begin errors++; $display("FAIL t2_c3 mem_req=%b stall_if=%b exp 0/1", mem_req, stall_if); end
        next_cyc(); @(negedge clock);
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h20 || stall_if !== 1'b1) begin errors++; $display("FAIL t2_c4_iissue req=%b addr=%h stall_if=%b exp 1/20/1", mem_req, mem_addr, stall_if); end
        next_cyc(); @(negedge clock);
        checks++; if (i_ack !== 1'b1 || i_rdata !== 32'h22222222 || stall_if !== 1'b0) begin errors++; $display("FAIL t2_c5_iack ack=%b rdata=%h stall_if=%b exp 1/22222222/0", i_ack, i_rdata, stall_if); end
        checks++; if (d_rdata !== 32'h11111111 || d_ack !== 1'b0) begin errors++; $display("FAIL t2_c5_dhold d_rdata=%h d_ack=%b exp 11111111/0", d_rdata, d_ack); end
        next_cyc(); i_req = 0;
    endtask

    task automatic test_streak();
        int exp_own[10];
        int s = 0;
        int n = 0;
        int got;
        for (int k = 0; k < 10; k++) begin
            if (s == MAXS) begin exp_own[k] = 0; s = 0; end
            else begin exp_own[k] = 1; s++; end
        end
        do_reset();
        i_req = 1; i_addr = 32'h100; d_req = 1; d_we = 0; d_addr = 32'h200; mem_ready = 1;
        for (int c = 0; c < 60 && n < 10; c++) begin
            @(negedge clock);
            if (i_ack || d_ack) begin
                got = (i_ack && d_ack) ? 2 : (i_ack ? 0 : 1);
                checks++; if (got !== exp_own[n]) begin errors++; $display("FAIL t3_order grant %0d got owner %0d exp %0d (0=I 1=D)", n, got, exp_own[n]); end
                n++;
            end
            next_cyc();
        end
        checks++; if (n !== 10) begin errors++; $display("FAIL t3_timeout completed %0d exp 10", n); end
        clear_inputs();
        next_cyc(); next_cyc();
    endtask

    task automatic test_write_wait();
        do_reset();
        d_req = 1; d_we = 0; d_addr = 32'h30; mem_ready = 1; mem_rdata = 32'hCAFEF00D;
        next_cyc(); next_cyc(); @(negedge clock);
        checks++; if (d_ack !== 1'b1 || d_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL t4_preread ack=%b rdata=%h exp 1/cafef00d", d_ack, d_rdata); end
        next_cyc();
        d_we = 1; d_addr = 32'h13; d_wdata = 32'hDEADBEEF; mem_ready = 0; mem_rdata = 32'h55555555;
        for (int k = 1; k <= 3; k++) begin
            next_cyc(); @(negedge clock);
            checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h10 || mem_we !== 1'b1 || mem_wdata !== 32'hDEADBEEF || d_ack !== 1'b0) begin
                errors++; $display("FAIL t4_wait c%0d req=%b addr=%h we=%b wdata=%h ack=%b exp 1/10/1/deadbeef/0", k, mem_req, mem_addr, mem_we, mem_wdata, d_ack);
            end
        end
        next_cyc(); mem_ready = 1; @(negedge clock);
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || d_ack !== 1'b0) begin errors++; $display("FAIL t4_c4 req=%b we=%b ack=%b exp 1/1/0", mem_req, mem_we, d_ack); end
        next_cyc(); mem_ready = 0; @(negedge clock);
        checks++; if (d_ack !== 1'b1 || d_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL t4_c5_ack ack=%b rdata=%h exp 1/cafef00d", d_ack, d_rdata); end
        next_cyc(); d_req = 0;
    endtask

    task automatic test_timeout();
        do_reset();
        i_req = 1; i_addr = 32'h40; mem_ready = 1; mem_rdata = 32'h12345678;
        next_cyc(); next_cyc(); @(negedge clock);
        checks++; if (i_ack !== 1'b1 || i_rdata !== 32'h12345678) begin errors++; $display("FAIL t5_preread ack=%b rdata=%h exp 1/12345678", i_ack, i_rdata); end
        next_cyc();
        i_addr = 32'h44; mem_ready = 0;
        for (int k = 1; k <= TMO; k++) begin
            next_cyc(); @(negedge clock);
            checks++; if (mem_req !== 1'b1 || i_ack !== 1'b0 || err_timeout !== 1'b0) begin errors++; $display("FAIL t5_wait c%0d req=%b ack=%b err=%b exp 1/0/0", k, mem_req, i_ack, err_timeout); end
        end
        next_cyc(); @(negedge clock);
        checks++; if (i_ack !== 1'b1 || i_rdata !== 32'h0 || err_timeout !== 1'b1 || mem_req !== 1'b0) begin
            errors++; $display("FAIL t5_abort ack=%b rdata=%h err=%b req=%b exp 1/0/1/0", i_ack, i_rdata, err_timeout, mem_req);
        end
        next_cyc(); i_req = 0;
        repeat (3) next_cyc();
        @(negedge clock);
        checks++; if (err_timeout !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL t5_sticky err=%b busy=%b exp 1/0", err_timeout, busy); end
        do_reset();
        @(negedge clock);
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL t5_clear err=%b exp 0", err_timeout); end
    endtask

    task automatic test_reset_midop();
        do_reset();
        i_req = 1; i_addr = 32'h44; mem_ready = 0;
        next_cyc(); @(negedge clock);
        checks++; if (mem_req !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL t6_issue req=%b busy=%b exp 1/1", mem_req, busy); end
        next_cyc();
        reset = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL t6_async req=%b busy=%b exp 0/0", mem_req, busy); end
        @(negedge clock);
        checks++; if (i_ack !== 1'b0) begin errors++; $display("FAIL t6_noack_c2 ack=%b exp 0", i_ack); end
        next_cyc(); reset = 1'b0; @(negedge clock);
        checks++; if (i_ack !== 1'b0 || mem_req !== 1'b0 || stall_if !== 1'b1) begin errors++; $display("FAIL t6_c3 ack=%b req=%b stall_if=%b exp 0/0/1", i_ack, mem_req, stall_if); end
        next_cyc(); mem_ready = 1; mem_rdata = 32'h0BADF00D; @(negedge clock);
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h44) begin errors++; $display("FAIL t6_reissue req=%b addr=%h exp 1/44", mem_req, mem_addr); end
        next_cyc(); @(negedge clock);
        checks++; if (i_ack !== 1'b1 || i_rdata !== 32'h0BADF00D || err_timeout !== 1'b0) begin errors++; $display("FAIL t6_done ack=%b rdata=%h err=%b exp 1/0badf00d/0", i_ack, i_rdata, err_timeout); end
        next_cyc(); i_req = 0; mem_ready = 0;
    endtask

    task automatic test_random();
        logic [31:0] mem_m [logic [31:0]];
        int streak_m = 0, wait_left = 0, cur_own = 0, ack_own = 0, n_txn = 0;
        logic prev_i = 0, prev_d = 0, prev_mreq = 0, ack_due = 0, i_rel = 0, d_rel = 0, gen_on = 1;
        logic cur_we = 0, exp_we;
        logic [31:0] exp_rd = '0, d_last = '0, cur_addr = '0, cur_wdata = '0, exp_addr;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (cyc == 500) gen_on = 0;
            checks++;
            if (i_ack !== (ack_due && ack_own == 0) || d_ack !== (ack_due && ack_own == 1)) begin
                errors++; $display("FAIL rnd_ack cyc %0d got i=%b d=%b exp due=%b own=%0d", cyc, i_ack, d_ack, ack_due, ack_own);
            end
            if (ack_due) begin
                checks++;
                if ((ack_own == 0 && i_rdata !== exp_rd) || (ack_own == 1 && d_rdata !== exp_rd)) begin
                    errors++; $display("FAIL rnd_rdata cyc %0d own=%0d got i=%h d=%h exp %h", cyc, ack_own, i_rdata, d_rdata, exp_rd);
                end
            end
            ack_due = 0;
            checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL rnd_err cyc %0d got %b exp 0", cyc, err_timeout); end

            if (i_rel) begin i_req = 0; i_rel = 0; end
            if (d_rel) begin d_req = 0; d_rel = 0; end
            if (i_ack) i_rel = 1;
            if (d_ack) d_rel = 1;
            if (gen_on && !i_req && $urandom_range(0, 2) != 0) begin
                i_req = 1; i_addr = 32'($urandom_range(0, 255));
            end
            if (gen_on && !d_req && $urandom_range(0, 2) != 0) begin
                d_req = 1; d_we = 1'($urandom_range(0, 1)); d_addr = 32'($urandom_range(0, 255)); d_wdata = $urandom;
            end

            mem_ready = 0; mem_rdata = $urandom;
            if (mem_req) begin
                if (!prev_mreq) begin
                    checks++; if (!(prev_i || prev_d)) begin errors++; $display("FAIL rnd_spurious cyc %0d mem_req without request", cyc); end
                    cur_own = (prev_i && (!prev_d || streak_m == MAXS)) ? 0 : 1;
                    if (cur_own == 0) streak_m = 0;
                    else if (prev_i && streak_m < MAXS) streak_m++;
                    exp_addr = (cur_own == 0) ? {i_addr[31:2], 2'b00} : {d_addr[31:2], 2'b00};
                    exp_we = (cur_own == 1) && d_we;
                    checks++;
                    if (mem_addr !== exp_addr || mem_we !== exp_we || (exp_we && mem_wdata !== d_wdata)) begin
                        errors++; $display("FAIL rnd_issue cyc %0d own=%0d got addr=%h we=%b wdata=%h exp addr=%h we=%b wdata=%h", cyc, cur_own, mem_addr, mem_we, mem_wdata, exp_addr, exp_we, d_wdata);
                    end
                    cur_addr = exp_addr; cur_we = exp_we; cur_wdata = d_wdata;
                    wait_left = $urandom_range(0, 3);
                    n_txn++;
                end else begin
                    checks++; if (mem_addr !== cur_addr || mem_we !== cur_we) begin errors++; $display("FAIL rnd_hold cyc %0d got %h/%b exp %h/%b", cyc, mem_addr, mem_we, cur_addr, cur_we); end
                end
                if (wait_left == 0) begin
                    mem_ready = 1;
                    if (cur_we) begin
                        mem_m[cur_addr] = cur_wdata;
                        exp_rd = d_last;
                    end else begin
                        mem_rdata = mem_m.exists(cur_addr) ? mem_m[cur_addr] : ~cur_addr;
                        exp_rd = mem_rdata;
                        if (cur_own == 1) d_last = mem_rdata;
                    end
                    ack_due = 1; ack_own = cur_own;
                end else begin
                    wait_left--;
                end
            end
            prev_mreq = mem_req; prev_i = i_req; prev_d = d_req;
            #1;
            checks++;
            if (stall_if !== (i_req && !i_ack) || stall_mem !== (d_req && !d_ack)) begin
                errors++; $display("FAIL rnd_stall cyc %0d got %b%b exp %b%b", cyc, stall_if, stall_mem, i_req && !i_ack, d_req && !d_ack);
            end
            next_cyc();
        end
        checks++; if ((i_req && !i_rel) || (d_req && !d_rel)) begin errors++; $display("FAIL rnd_drain requests still pending i=%b d=%b exp 0/0", i_req, d_req); end
        checks++; if (n_txn < 50) begin errors++; $display("FAIL rnd_count transactions %0d exp >= 50", n_txn); end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_i_read();
        test_d_priority();
        test_streak();
        test_write_wait();
        test_timeout();
        test_reset_midop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not complete by %0t", $time);
        $fatal(1);
    end

endmodule
